// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
// State encoding, instruction size and the default address width.
package pc_gen_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_BYTES  = 4;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

    function automatic logic low_bits_set(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack for pc_gen (built only with PC_RAS_EN).
// A full push overwrites the oldest entry; count saturates at DEPTH.
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [PW:0]     count_q;
    logic [PW-1:0]   top_idx;
    logic            do_pop;
    logic            full;

    assign top_idx = ptr_q - PW'(1);
    assign top_o   = mem_q[top_idx];
    assign empty_o = count_q == '0;
    assign full    = count_q == (PW+1)'(DEPTH);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (do_pop && !push_i) begin
            ptr_q   <= ptr_q - PW'(1);
            count_q <= count_q - (PW+1)'(1);
        end else if (push_i && !do_pop) begin
            ptr_q   <= ptr_q + PW'(1);
            count_q <= full ? count_q : count_q + (PW+1)'(1);
        end
    end

    // Pop-then-push replaces the top in place; pointer and count stay put.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push_i && do_pop)
                mem_q[top_idx] <= push_data_i;
            else if (push_i)
                mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: BOOT/RUN/HALT, trap/redirect priority, handshake.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            fetch_ready,
`ifdef PC_RAS_EN
    input  logic            call_valid,
    input  logic            ret_valid,
`endif
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned,
    output logic            halted
);

    if (XLEN < 8 || RESET_VECTOR[1:0] != 2'b00 || RAS_DEPTH < 2 ||
        (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_params
        $error("pc_gen: illegal parameter set");
    end

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic            fetch_valid_q;
    logic            halted_q;
    logic            misaligned_q;

    logic            fire;
    logic            advance;
    logic [XLEN-1:0] seq_pc;

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + XLEN'(INSTR_BYTES);
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;
    assign misaligned  = misaligned_q;

    assign fire    = fetch_valid_q & fetch_ready;
    assign advance = fire & ~trap_valid & ~redirect_valid & ~halt_req & ~stall;

`ifdef PC_RAS_EN
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (advance & call_valid),
        .pop_i       (advance & ret_valid),
        .push_data_i (pc_plus4),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );

    assign seq_pc = (ret_valid && !ras_empty) ? ras_top : pc_plus4;
`else
    assign seq_pc = pc_plus4;
`endif

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= PC_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            unique case (state_q)
                PC_BOOT: begin
                    state_q       <= PC_RUN;
                    fetch_valid_q <= 1'b1;
                end
                PC_RUN: begin
                    if (trap_valid) begin
                        pc_q         <= align(trap_vector);
                        misaligned_q <= low_bits_set(trap_vector[1:0]);
                    end else if (redirect_valid) begin
                        pc_q         <= align(redirect_addr);
                        misaligned_q <= low_bits_set(redirect_addr[1:0]);
                    end else if (halt_req) begin
                        state_q       <= PC_HALT;
                        fetch_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                    end else if (advance) begin
                        pc_q <= seq_pc;
                    end
                end
                PC_HALT: begin
                    // Interrupts wake the core; plain redirects do not.
                    if (trap_valid || resume) begin
                        state_q       <= PC_RUN;
                        fetch_valid_q <= 1'b1;
                        halted_q      <= 1'b0;
                    end
                    if (trap_valid) begin
                        pc_q         <= align(trap_vector);
                        misaligned_q <= low_bits_set(trap_vector[1:0]);
                    end
                end
                default: begin
                    state_q       <= PC_BOOT;
                    fetch_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: spec-level model compared every cycle plus directed literals.
// RAS scenario runs only when PC_RAS_EN is defined.
module tb_pc_gen;

    localparam int          XLEN  = 32;
    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 4;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        halt_req;
    logic        resume;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        halted;
`ifdef PC_RAS_EN
    logic        call_valid;
    logic        ret_valid;
`endif

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .halt_req       (halt_req),
        .resume         (resume),
        .fetch_ready    (fetch_ready),
`ifdef PC_RAS_EN
        .call_valid     (call_valid),
        .ret_valid      (ret_valid),
`endif
        .fetch_valid    (fetch_valid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .misaligned     (misaligned),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec-level model: pc value, mode, pending misaligned flag, stack as a queue.
    int          m_st;
    logic [31:0] m_pc;
    logic        m_mis;
    bit          m_live = 0;
    logic [31:0] m_stack[$];
    logic [31:0] m_nxt;

    always @(posedge clk) begin
        m_live = 1;
        if (reset) begin
            m_pc  = RV;
            m_st  = M_BOOT;
            m_mis = 1'b0;
            m_stack.delete();
        end else begin
            m_mis = 1'b0;
            if (m_st == M_BOOT) begin
                m_st = M_RUN;
            end else if (m_st == M_RUN) begin
                if (trap_valid) begin
                    m_pc  = trap_vector & 32'hFFFF_FFFC;
                    m_mis = trap_vector[1:0] != 2'b00;
                end else if (redirect_valid) begin
                    m_pc  = redirect_addr & 32'hFFFF_FFFC;
                    m_mis = redirect_addr[1:0] != 2'b00;
                end else if (halt_req) begin
                    m_st = M_HALT;
                end else if (!stall && fetch_ready) begin
                    m_nxt = m_pc + 32'd4;
`ifdef PC_RAS_EN
                    if (ret_valid && m_stack.size() > 0)
                        m_nxt = m_stack.pop_back();
                    if (call_valid) begin
                        m_stack.push_back(m_pc + 32'd4);
                        if (m_stack.size() > DEPTH)
                            void'(m_stack.pop_front());
                    end
`endif
                    m_pc = m_nxt;
                end
            end else begin
                if (trap_valid) begin
                    m_pc  = trap_vector & 32'hFFFF_FFFC;
                    m_mis = trap_vector[1:0] != 2'b00;
                    m_st  = M_RUN;
                end else if (resume) begin
                    m_st = M_RUN;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            cmp("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_st == M_RUN});
            cmp("halted", {31'd0, halted}, {31'd0, m_st == M_HALT});
            cmp("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
            cmp("pc", pc, m_pc);
            cmp("pc_plus4", pc_plus4, m_pc + 32'd4);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic clr();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        trap_valid     = 1'b0;
        trap_vector    = '0;
        halt_req       = 1'b0;
        resume         = 1'b0;
`ifdef PC_RAS_EN
        call_valid     = 1'b0;
        ret_valid      = 1'b0;
`endif
    endtask

    initial begin
        clr();
        reset       = 1'b1;
        fetch_ready = 1'b1;
        tick();
        cmp("rst_pc", pc, 32'h100);
        cmp("rst_fv", {31'd0, fetch_valid}, 32'd0);
        cmp("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        tick();
        cmp("boot_pc", pc, 32'h100);
        cmp("run_fv", {31'd0, fetch_valid}, 32'd1);
        tick();
        cmp("seq1", pc, 32'h104);
        tick();
        cmp("seq2", pc, 32'h108);

        fetch_ready = 1'b0;
        repeat (3) tick();
        cmp("bp_hold", pc, 32'h108);

        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h2003;
        tick();
        cmp("redir_stall", pc, 32'h2000);
        cmp("mis_pulse", {31'd0, misaligned}, 32'd1);
        redirect_valid = 1'b0;
        tick();
        cmp("mis_drop", {31'd0, misaligned}, 32'd0);
        cmp("stall_hold", pc, 32'h2000);

        clr();
        trap_valid     = 1'b1;
        trap_vector    = 32'h80;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h400;
        tick();
        cmp("trap_prio", pc, 32'h80);
        clr();
        fetch_ready = 1'b1;
        tick();
        cmp("after_trap", pc, 32'h84);

        halt_req = 1'b1;
        resume   = 1'b1;
        tick();
        cmp("halt_in", {31'd0, halted}, 32'd1);
        cmp("halt_fv", {31'd0, fetch_valid}, 32'd0);
        clr();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h500;
        tick();
        cmp("halt_ign_redir", pc, 32'h84);
        clr();
        resume = 1'b1;
        tick();
        cmp("resumed", {31'd0, halted}, 32'd0);
        clr();
        tick();
        cmp("resume_seq", pc, 32'h88);
        halt_req = 1'b1;
        tick();
        clr();
        trap_valid  = 1'b1;
        trap_vector = 32'h301;
        tick();
        cmp("wake_pc", pc, 32'h300);
        cmp("wake_halted", {31'd0, halted}, 32'd0);
        clr();

        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFC;
        tick();
        cmp("wrap_p4", pc_plus4, 32'h0);
        clr();
        tick();
        cmp("wrap", pc, 32'h0);
        cmp("wrap_nomis", {31'd0, misaligned}, 32'd0);

        halt_req = 1'b1;
        tick();
        clr();
        reset = 1'b1;
        tick();
        cmp("rst_halt_pc", pc, 32'h100);
        cmp("rst_halt_h", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        cmp("reboot_seq", pc, 32'h104);

`ifdef PC_RAS_EN
        for (int k = 1; k <= 5; k++) begin
            redirect_valid = 1'b1;
            redirect_addr  = 32'(k * 16);
            tick();
            redirect_valid = 1'b0;
            call_valid     = 1'b1;
            tick();
            call_valid     = 1'b0;
        end
        cmp("ras_call_pc", pc, 32'h54);
        begin
            logic [31:0] exp_ret [5];
            exp_ret[0] = 32'h54;
            exp_ret[1] = 32'h44;
            exp_ret[2] = 32'h34;
            exp_ret[3] = 32'h24;
            exp_ret[4] = 32'h28;
            ret_valid = 1'b1;
            for (int r = 0; r < 5; r++) begin
                tick();
                cmp($sformatf("ras_ret%0d", r), pc, exp_ret[r]);
            end
            ret_valid = 1'b0;
        end
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage; successor to the fixed-width, increment-only PC register.
- Adds a configurable reset vector and a boot/run/halt state machine.
- Adds prioritised redirect sources (trap, branch/jump) and a valid/ready fetch handshake.
- Sits between the branch/exception logic and the instruction memory port.

Parameters:
- XLEN, 32, PC and address width in bits (≥ 8).
- RESET_VECTOR, 0, PC value loaded on reset; bits [1:0] must be 0.
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥ 2); used only with PC_RAS_EN.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC (pipeline hazard).
- redirect_valid  in  1  branch/jump taken.
- redirect_addr  in  XLEN  branch/jump target.
- trap_valid  in  1  exception/interrupt entry.
- trap_vector  in  XLEN  trap handler address.
- halt_req  in  1  request halt (debug/WFI).
- resume  in  1  leave HALT.
- fetch_ready  in  1  instruction memory accepts address.
- fetch_valid  out  1  pc is a valid fetch request.
- pc  out  XLEN  current fetch address (registered).
- pc_plus4  out  XLEN  pc+4, combinational.
- misaligned  out  1  one-cycle pulse: accepted redirect/trap target had bits [1:0] ≠ 0.
- halted  out  1  high while in HALT.
- call_valid, ret_valid  in  1 each  only with PC_RAS_EN.

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset values: pc=RESET_VECTOR, state=BOOT, fetch_valid=0, misaligned=0, halted=0; RAS pointer and count 0.
- State BOOT:
  - Lasts exactly one cycle after reset deasserts; fetch_valid=0.
  - Next state is RUN; pc is unchanged.
- State RUN:
  - fetch_valid=1.
  - fire = fetch_valid & fetch_ready.
- Next-pc priority, highest first:
  - reset.
  - trap_valid → pc=trap_vector.
  - redirect_valid → pc=redirect_addr.
  - halt_req → state HALT, pc held.
  - stall → pc held.
  - fire → pc=pc+4.
  - otherwise pc held (memory backpressure).
- Trap and redirect are taken even when stall=1 or fetch_ready=0; they flush the current request.
- Redirect/trap targets are loaded with bits [1:0] forced to 0. If the raw target had bits [1:0] ≠ 0, misaligned=1 in the cycle after the load.
- Arithmetic: pc+4 is modulo 2^XLEN; pc=2^XLEN−4 wraps to 0 with no flag.
- State HALT:
  - fetch_valid=0, halted=1, pc held.
  - resume → RUN next cycle.
  - trap_valid in HALT loads trap_vector and returns to RUN (interrupt wakes the core).
  - redirect_valid in HALT is ignored.
- halt_req and resume both high in RUN: halt wins; resume is sampled only in HALT.
- Reset asserted in any state restores reset values on the next edge; any in-flight request is dropped.
- fetch_valid is a function of state only, never of fetch_ready.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined:
  - Return-address stack of RAS_DEPTH×XLEN.
  - call_valid & fire pushes pc+4.
  - ret_valid & fire with count>0 pops, and the next pc becomes the popped value. This ranks below redirect/trap and above sequential.
  - Push when full overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
  - ret_valid with count=0: no pop; pc advances sequentially.
  - call_valid & ret_valid together: pop then push (top replaced by pc+4); next pc is the old top.
  - trap_valid does not touch the stack.
- Undefined: call_valid/ret_valid ports and all RAS logic absent; behaviour identical to the above without RAS.

Decomposition:
- Shared package holds:
  - state encoding PC_BOOT=2'd0, PC_RUN=2'd1, PC_HALT=2'd2.
  - INSTR_BYTES=4.
  - XLEN default.
- Natural sub-module: pc_ras (stack storage, pointer, count, push/pop), instantiated only under PC_RAS_EN.

Test Plan:
- Boot: RESET_VECTOR=0x100, release reset, fetch_ready=1 → pc 0x100 for BOOT and first RUN cycle, then 0x104, 0x108; fetch_valid 0 then 1.
- Backpressure and stall: fetch_ready=0 for 3 cycles → pc held at 0x108. stall=1 with redirect_valid=1, redirect_addr=0x2003 → pc=0x2000 and misaligned pulses once.
- Priority: trap_valid and redirect_valid together, trap_vector=0x80, redirect_addr=0x400 → pc=0x80.
- Halt/wake: halt_req → halted=1, fetch_valid=0, pc frozen. resume → RUN. A second halt followed by trap_valid → pc=trap_vector, halted=0.
- Wrap and reset: pc=0xFFFFFFFC with fire → pc=0. Reset asserted during HALT → pc=RESET_VECTOR, state BOOT.
- RAS (PC_RAS_EN, depth 4): calls at 0x10, 0x20, 0x30, 0x40, 0x50, then 5 rets → pops 0x54, 0x44, 0x34, 0x24; fifth ret falls through sequentially.
